// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with an iterative unsigned multiply/divide
// unit. Multiply and divide results are written to HI/LO on completion.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       aluCtrl_in,
    input  logic             start_in,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             divZero_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    // acc_hi/acc_lo: partial product (MUL) or remainder/quotient (DIV)
    logic [WIDTH-1:0] acc_hi, acc_hi_next;
    logic [WIDTH-1:0] acc_lo, acc_lo_next;
    // opnd: multiplicand (MUL) or divisor (DIV), frozen for the whole operation
    logic [WIDTH-1:0] opnd, opnd_next;
    logic [WIDTH-1:0] hi_next, lo_next, alu_next;
    logic             zero_next, valid_next, divzero_next;

    logic [WIDTH-1:0] alu_result;
    logic             load;
    logic [WIDTH-1:0] load_value;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_new, mul_lo_new;
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_new = mul_sum[WIDTH:1];
    assign mul_lo_new = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring step: shift in next dividend bit, subtract divisor if it fits.
    // The remainder is always below the divisor, so the difference fits in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_rem_new, div_quo_new;
    assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_fits    = (div_shift >= {1'b0, opnd});
    assign div_rem_new = div_fits ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
    assign div_quo_new = {acc_lo[WIDTH-2:0], div_fits};

    assign busy_out = (state != IDLE);

    // Single-cycle ALU result for the current operation select
    always_comb begin
        alu_result = '0;
        case (aluCtrl_in)
            OP_AND:  alu_result = a_in & b_in;
            OP_OR:   alu_result = a_in | b_in;
            OP_ADD:  alu_result = a_in + b_in;
            OP_SUB:  alu_result = a_in - b_in;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_NOR:  alu_result = ~(a_in | b_in);
            OP_MFHI: alu_result = hi_out;
            OP_MFLO: alu_result = lo_out;
            default: alu_result = '0;
        endcase
    end

    // Next-state and next-output logic for the IDLE/MUL/DIV controller
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next   = state;
        count_next   = count;
        acc_hi_next  = acc_hi;
        acc_lo_next  = acc_lo;
        opnd_next    = opnd;
        hi_next      = hi_out;
        lo_next      = lo_out;
        divzero_next = divZero_out;
        load         = 1'b0;
        load_value   = '0;

        case (state)
            IDLE: begin
                if (start_in) begin
                    count_next = '0;
                    if (aluCtrl_in == OP_MULTU) begin
                        state_next  = MUL;
                        acc_hi_next = '0;
                        acc_lo_next = b_in;
                        opnd_next   = a_in;
                    end else if (aluCtrl_in == OP_DIVU) begin
                        if (b_in == '0) begin
                            hi_next      = a_in;
                            lo_next      = '1;
                            divzero_next = 1'b1;
                            load         = 1'b1;
                            load_value   = '1;
                        end else begin
                            state_next  = DIV;
                            acc_hi_next = '0;
                            acc_lo_next = a_in;
                            opnd_next   = b_in;
                        end
                    end else begin
                        load       = 1'b1;
                        load_value = alu_result;
                    end
                end
            end
            MUL: begin
                acc_hi_next = mul_hi_new;
                acc_lo_next = mul_lo_new;
                count_next  = count + CW'(1);
                if (count == LAST) begin
                    state_next = IDLE;
                    hi_next    = mul_hi_new;
                    lo_next    = mul_lo_new;
                    load       = 1'b1;
                    load_value = mul_lo_new;
                end
            end
            DIV: begin
                acc_hi_next = div_rem_new;
                acc_lo_next = div_quo_new;
                count_next  = count + CW'(1);
                if (count == LAST) begin
                    state_next   = IDLE;
                    hi_next      = div_rem_new;
                    lo_next      = div_quo_new;
                    divzero_next = 1'b0;
                    load         = 1'b1;
                    load_value   = div_quo_new;
                end
            end
            default: state_next = IDLE;
        endcase

        alu_next   = alu_out;
        zero_next  = zero_out;
        valid_next = 1'b0;
        if (load) begin
            alu_next   = load_value;
            zero_next  = (load_value == '0);
            valid_next = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_in) begin
            state       <= IDLE;
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            alu_out     <= '0;
            zero_out    <= 1'b1;
            valid_out   <= 1'b0;
            divZero_out <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            acc_hi      <= acc_hi_next;
            acc_lo      <= acc_lo_next;
            opnd        <= opnd_next;
            hi_out      <= hi_next;
            lo_out      <= lo_next;
            alu_out     <= alu_next;
            zero_out    <= zero_next;
            valid_out   <= valid_next;
            divZero_out <= divzero_next;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv (WIDTH=16) checked against
// an arithmetic reference model every cycle plus hand-computed literals.
module tb_alu_muldiv;

    localparam int W = 16;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    logic         clock_in;
    logic         reset_in;
    logic [W-1:0] a_in, b_in;
    logic [3:0]   aluCtrl_in;
    logic         start_in;
    logic [W-1:0] alu_out, hi_out, lo_out;
    logic         zero_out, valid_out, busy_out, divZero_out;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .aluCtrl_in  (aluCtrl_in),
        .start_in    (start_in),
        .alu_out     (alu_out),
        .zero_out    (zero_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .divZero_out (divZero_out),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Results are computed with plain *, /, %; a pending long op completes W edges after acceptance.
    logic [W-1:0] m_alu, m_hi, m_lo, p_hi, p_lo, r;
    logic         m_zero, m_valid, m_dz, p_div;
    int           m_left;
    logic [2*W-1:0] prod;

    always @(posedge clock_in) begin
        if (reset_in) begin
            m_alu = '0; m_hi = '0; m_lo = '0; m_zero = 1'b1;
            m_valid = 1'b0; m_dz = 1'b0; m_left = 0;
        end else begin
            m_valid = 1'b0;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_alu = p_lo;
                    m_zero = (p_lo == 0); m_valid = 1'b1;
                    if (p_div) m_dz = 1'b0;
                end
            end else if (start_in) begin
                case (aluCtrl_in)
                    OP_MULTU: begin
                        prod = (2*W)'(a_in) * (2*W)'(b_in);
                        p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0];
                        p_div = 1'b0; m_left = W;
                    end
                    OP_DIVU: begin
                        if (b_in == 0) begin
                            m_hi = a_in; m_lo = '1; m_alu = '1; m_zero = 1'b0;
                            m_dz = 1'b1; m_valid = 1'b1;
                        end else begin
                            p_lo = a_in / b_in; p_hi = a_in % b_in;
                            p_div = 1'b1; m_left = W;
                        end
                    end
                    default: begin
                        case (aluCtrl_in)
                            OP_AND:  r = a_in & b_in;
                            OP_OR:   r = a_in | b_in;
                            OP_ADD:  r = a_in + b_in;
                            OP_SUB:  r = a_in - b_in;
                            OP_SLT:  r = (a_in < b_in) ? 1 : 0;
                            OP_NOR:  r = ~(a_in | b_in);
                            OP_MFHI: r = m_hi;
                            OP_MFLO: r = m_lo;
                            default: r = 0;
                        endcase
                        m_alu = r; m_zero = (r == 0); m_valid = 1'b1;
                    end
                endcase
            end
        end
    end

    // Compare every output against the model each cycle, away from the active edge
    always @(negedge clock_in) begin
        if (check_en) begin
            check("m_alu",   alu_out,     m_alu);
            check("m_zero",  zero_out,    m_zero);
            check("m_valid", valid_out,   m_valid);
            check("m_busy",  busy_out,    (m_left != 0));
            check("m_hi",    hi_out,      m_hi);
            check("m_lo",    lo_out,      m_lo);
            check("m_dz",    divZero_out, m_dz);
        end
    end

    // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        aluCtrl_in = op; a_in = a; b_in = b; start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
    endtask

    task automatic run_long(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit perturb);
        int n;
        issue(op, a, b);
        n = 0;
        while (busy_out && n < 64) begin
            if (perturb && n == 3) begin
                a_in = 16'h1234; b_in = 16'h0000; aluCtrl_in = OP_ADD; start_in = 1'b1;
            end else begin
                start_in = 1'b0;
            end
            n++;
            @(negedge clock_in);
        end
        start_in = 1'b0;
        check("busy_cycles", n, W);
        check("long_valid", valid_out, 1'b1);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[11];
    vec_t longs[5];

    initial begin
        vecs[0]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[1]  = '{OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC};
        vecs[2]  = '{OP_ADD, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[3]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE};
        vecs[4]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000};
        vecs[5]  = '{OP_SLT, 16'h0001, 16'h8000, 16'h0001};
        vecs[6]  = '{OP_SLT, 16'h8000, 16'h0001, 16'h0000};
        vecs[7]  = '{OP_SLT, 16'h0007, 16'h0007, 16'h0000};
        vecs[8]  = '{OP_NOR, 16'h00FF, 16'h0F00, 16'hF000};
        vecs[9]  = '{4'b1111, 16'hABCD, 16'h1234, 16'h0000};
        vecs[10] = '{4'b0011, 16'hFFFF, 16'hFFFF, 16'h0000};

        longs[0] = '{OP_MULTU, 16'h1234, 16'h0056, 16'h0000};
        longs[1] = '{OP_MULTU, 16'h0000, 16'hABCD, 16'h0000};
        longs[2] = '{OP_DIVU,  16'hFFFF, 16'h0001, 16'h0000};
        longs[3] = '{OP_DIVU,  16'h0005, 16'hFFFF, 16'h0000};
        longs[4] = '{OP_DIVU,  16'hABCD, 16'h0010, 16'h0000};

        reset_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; aluCtrl_in = '0;
        repeat (2) @(negedge clock_in);
        check_en = 1'b1;
        check("rst_alu",   alu_out, 16'h0000);
        check("rst_zero",  zero_out, 1'b1);
        check("rst_valid", valid_out, 1'b0);
        check("rst_busy",  busy_out, 1'b0);
        check("rst_hilo",  {hi_out, lo_out}, 32'h0);
        check("rst_dz",    divZero_out, 1'b0);
        reset_in = 1'b0;
        @(negedge clock_in);

        // Single-cycle ops: result and one-cycle valid pulse
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check("sc_alu",   alu_out, vecs[i].exp);
            check("sc_zero",  zero_out, (vecs[i].exp == 0));
            check("sc_valid", valid_out, 1'b1);
            @(negedge clock_in);
            check("sc_valid_drop", valid_out, 1'b0);
            check("sc_hold",  alu_out, vecs[i].exp);
        end

        // MULTU max operands, with operand changes and an ignored start mid-operation
        run_long(OP_MULTU, 16'hFFFF, 16'hFFFF, 1'b1);
        check("mul_hi",  hi_out, 16'hFFFE);
        check("mul_lo",  lo_out, 16'h0001);
        check("mul_alu", alu_out, 16'h0001);

        // New op accepted in the very cycle busy falls
        issue(OP_ADD, 16'h0010, 16'h0020);
        check("b2b_alu",   alu_out, 16'h0030);
        check("b2b_valid", valid_out, 1'b1);
        check("b2b_hi",    hi_out, 16'hFFFE);

        // DIVU 100/7 then MFHI/MFLO
        run_long(OP_DIVU, 16'h0064, 16'h0007, 1'b0);
        check("div_lo", lo_out, 16'h000E);
        check("div_hi", hi_out, 16'h0002);
        check("div_dz", divZero_out, 1'b0);
        issue(OP_MFHI, 16'h0000, 16'h0000);
        check("mfhi", alu_out, 16'h0002);
        issue(OP_MFLO, 16'h0000, 16'h0000);
        check("mflo", alu_out, 16'h000E);

        foreach (longs[i]) run_long(longs[i].op, longs[i].a, longs[i].b, 1'b0);
        check("div_last_lo", lo_out, 16'h0ABC);
        check("div_last_hi", hi_out, 16'h000D);

        // Divide by zero: immediate result, never busy
        issue(OP_DIVU, 16'h1234, 16'h0000);
        check("dz_lo",    lo_out, 16'hFFFF);
        check("dz_hi",    hi_out, 16'h1234);
        check("dz_flag",  divZero_out, 1'b1);
        check("dz_busy",  busy_out, 1'b0);
        check("dz_valid", valid_out, 1'b1);
        check("dz_alu",   alu_out, 16'hFFFF);
        @(negedge clock_in);
        check("dz_busy2", busy_out, 1'b0);

        // divZero holds across a MULTU
        run_long(OP_MULTU, 16'h0003, 16'h0005, 1'b0);
        check("dz_hold", divZero_out, 1'b1);
        check("mul15",   lo_out, 16'h000F);

        // Reset aborts MULTU; ADD mid-operation ignored; no valid pulse
        begin
            int vcount;
            vcount = 0;
            issue(OP_MULTU, 16'hFFFF, 16'hFFFF);
            for (int cyc = 1; cyc < 10; cyc++) begin
                if (cyc == 5) begin
                    aluCtrl_in = OP_ADD; a_in = 16'h0001; b_in = 16'h0001; start_in = 1'b1;
                end else begin
                    start_in = 1'b0;
                end
                @(negedge clock_in);
                if (valid_out) vcount++;
            end
            start_in = 1'b0;
            reset_in = 1'b1;
            @(negedge clock_in);
            reset_in = 1'b0;
            check("abort_no_valid", vcount, 0);
            check("abort_alu",   alu_out, 16'h0000);
            check("abort_zero",  zero_out, 1'b1);
            check("abort_valid", valid_out, 1'b0);
            check("abort_busy",  busy_out, 1'b0);
            check("abort_hilo",  {hi_out, lo_out}, 32'h0);
            check("abort_dz",    divZero_out, 1'b0);
            repeat (W + 2) @(negedge clock_in);
            check("abort_still_idle", valid_out, 1'b0);
        end

        run_long(OP_DIVU, 16'h000A, 16'h0003, 1'b0);
        check("div10_lo", lo_out, 16'h0003);
        check("div10_hi", hi_out, 16'h0001);

        repeat (3) @(negedge clock_in);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
